// File: rtl/downlink_frame_sender_if.sv
// Write-side handshake bus for downlink_frame_sender.
//   wr_data  : word to queue
//   wr_valid : write request from the producer
//   wr_ready : the FIFO can accept a word this cycle
// Modports: master = producer (software-side logic), slave = frame sender.
interface downlink_frame_sender_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  modport master (output wr_data, output wr_valid, input  wr_ready);
  modport slave  (input  wr_data, input  wr_valid, output wr_ready);
endinterface

// File: rtl/downlink_frame_sender.sv
// downlink_frame_sender: queues 32-bit downlink user words in a FIFO and
// emits one word per 40 MHz frame onto the lpGBT downlink user-data bus.
// The idle word is sent when nothing is popped.
//
// Ports:
//   clk40_i, rst_i        frame clock, synchronous active-high reset
//   wr_if (slave)         write handshake (wr_data / wr_valid / wr_ready)
//   enable_i              transmit enable (level)
//   clr_stat_i            clears sent and starve counters (clear wins)
//   downlinkrdy_i         lpGBT downlink ready
//   downlinkUserData_o    registered downlink word
//   frame_valid_o         downlinkUserData_o carries a FIFO word
//   count_o/full_o/empty_o  FIFO status
//   state_o               0 = IDLE, 1 = PREFILL, 2 = RUN
//   sent_cnt_o            words transmitted (wraps)
//   starve_cnt_o          RUN frames with ready link and empty FIFO (saturates)
//
// Optional build macro DL_LOOP_EN adds loop_i: in RUN the FIFO contents are
// replayed round-robin through a replay pointer without being consumed.
module downlink_frame_sender #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 16,
  parameter int                START_LVL = 4,
  parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
  input  logic                       clk40_i,
  input  logic                       rst_i,
  downlink_frame_sender_if.slave     wr_if,
  input  logic                       enable_i,
  input  logic                       clr_stat_i,
  input  logic                       downlinkrdy_i,
`ifdef DL_LOOP_EN
  input  logic                       loop_i,
`endif
  output logic [DATA_W-1:0]          downlinkUserData_o,
  output logic                       frame_valid_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [1:0]                 state_o,
  output logic [31:0]                sent_cnt_o,
  output logic [15:0]                starve_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic [DATA_W-1:0] dl_data_q, dl_data_d;
  logic              frame_valid_q, frame_valid_d;
  logic [31:0]       sent_q, sent_d;
  logic [15:0]       starve_q, starve_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              loop_act, wr_en, run_ok, pop, send, starve_inc;
  logic [DATA_W-1:0] send_word;

`ifdef DL_LOOP_EN
  logic [CW-1:0]     rp_q, rp_d;
  assign loop_act = loop_i;
`else
  assign loop_act = 1'b0;
`endif

  // Ready drops during reset and while replaying so the replay window is stable.
  assign wr_if.wr_ready = ~full_q & ~rst_i & ~loop_act;
  assign wr_en          = wr_if.wr_valid & wr_if.wr_ready;

  always_comb begin
    run_ok     = (state_q == RUN) & downlinkrdy_i & enable_i & ~empty_q;
    pop        = run_ok & ~loop_act;
    send       = run_ok;
    starve_inc = (state_q == RUN) & downlinkrdy_i & enable_i & empty_q;
    send_word  = mem_q[rd_ptr_q[AW-1:0]];
`ifdef DL_LOOP_EN
    if (loop_i) send_word = mem_q[rp_q[AW-1:0]];
`endif

    wr_ptr_d = wr_ptr_q + CW'(wr_en);
    rd_ptr_d = rd_ptr_q + CW'(pop);
    count_d  = wr_ptr_d - rd_ptr_d;
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);

    dl_data_d     = send ? send_word : IDLE_WORD;
    frame_valid_d = send;

    if (clr_stat_i) sent_d = '0;
    else            sent_d = sent_q + 32'(send);

    if (clr_stat_i)                        starve_d = '0;
    else if (starve_inc && starve_q != '1) starve_d = starve_q + 16'd1;
    else                                   starve_d = starve_q;
  end

`ifdef DL_LOOP_EN
  // Replay pointer tracks the post-pop read pointer until looping starts,
  // then cycles rd_ptr .. wr_ptr-1.
  always_comb begin
    rp_d = rp_q;
    if (!loop_i)     rp_d = rd_ptr_d;
    else if (run_ok) rp_d = (rp_q + CW'(1) == wr_ptr_q) ? rd_ptr_q : rp_q + CW'(1);
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_i) state_d = PREFILL;
      PREFILL: begin
        if (!enable_i)                                           state_d = IDLE;
        else if (count_o >= CW'(START_LVL) && downlinkrdy_i)     state_d = RUN;
      end
      RUN:     if (!enable_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk40_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      dl_data_q     <= IDLE_WORD;
      frame_valid_q <= 1'b0;
      sent_q        <= '0;
      starve_q      <= '0;
`ifdef DL_LOOP_EN
      rp_q          <= '0;
`endif
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      dl_data_q     <= dl_data_d;
      frame_valid_q <= frame_valid_d;
      sent_q        <= sent_d;
      starve_q      <= starve_d;
`ifdef DL_LOOP_EN
      rp_q          <= rp_d;
`endif
    end
  end

  // Storage needs no reset; only words behind the write pointer are ever read.
  always_ff @(posedge clk40_i) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_if.wr_data;
  end

  assign downlinkUserData_o = dl_data_q;
  assign frame_valid_o      = frame_valid_q;
  assign count_o            = wr_ptr_q - rd_ptr_q;
  assign full_o             = full_q;
  assign empty_o            = empty_q;
  assign state_o            = state_q;
  assign sent_cnt_o         = sent_q;
  assign starve_cnt_o       = starve_q;
endmodule

// File: tb/tb_downlink_frame_sender.sv
module tb_downlink_frame_sender;
  logic        clk40_i = 1'b0;
  logic        rst_i   = 1'b1;
  logic        enable_i = 1'b0;
  logic        clr_stat_i = 1'b0;
  logic        downlinkrdy_i = 1'b0;
  logic        loop_i = 1'b0;
  logic [31:0] downlinkUserData_o;
  logic        frame_valid_o;
  logic [4:0]  count_o;
  logic        full_o, empty_o;
  logic [1:0]  state_o;
  logic [31:0] sent_cnt_o;
  logic [15:0] starve_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  downlink_frame_sender_if #(.DATA_W(32)) wr_if ();

  downlink_frame_sender dut (
    .clk40_i            (clk40_i),
    .rst_i              (rst_i),
    .wr_if              (wr_if),
    .enable_i           (enable_i),
    .clr_stat_i         (clr_stat_i),
    .downlinkrdy_i      (downlinkrdy_i),
`ifdef DL_LOOP_EN
    .loop_i             (loop_i),
`endif
    .downlinkUserData_o (downlinkUserData_o),
    .frame_valid_o      (frame_valid_o),
    .count_o            (count_o),
    .full_o             (full_o),
    .empty_o            (empty_o),
    .state_o            (state_o),
    .sent_cnt_o         (sent_cnt_o),
    .starve_cnt_o       (starve_cnt_o)
  );

  always #5 clk40_i = ~clk40_i;

  task automatic tick();
    @(posedge clk40_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = w;
    tick();
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic do_reset();
    enable_i = 1'b0; downlinkrdy_i = 1'b0; clr_stat_i = 1'b0; loop_i = 1'b0;
    wr_if.wr_valid = 1'b0;
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic go_run();
    enable_i = 1'b1; downlinkrdy_i = 1'b1;
    tick(); chk("prefill", state_o, 1);
    tick(); chk("run", state_o, 2);
  endtask

  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = '0;

    // reset values
    tick(); tick();
    chk("rst_ready", wr_if.wr_ready, 0);
    chk("rst_state", state_o, 0);
    chk("rst_data",  downlinkUserData_o, 0);
    chk("rst_fv",    frame_valid_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full",  full_o, 0);
    rst_i = 1'b0;
    tick();
    chk("ready_after_rst", wr_if.wr_ready, 1);

    // basic 4-word stream, then starve accounting
    for (int i = 1; i <= 4; i++) push(32'h1111_1111 * i);
    chk("t1_count", count_o, 4);
    go_run();
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t1_data", downlinkUserData_o, 32'h1111_1111 * i);
      chk("t1_fv",   frame_valid_o, 1);
    end
    tick();
    chk("t1_idle", downlinkUserData_o, 0);
    chk("t1_fv0",  frame_valid_o, 0);
    chk("t1_sent", sent_cnt_o, 4);
    chk("starve1", starve_cnt_o, 1);
    for (int i = 0; i < 9; i++) tick();
    chk("starve10", starve_cnt_o, 10);
    chk("starve_state", state_o, 2);
    clr_stat_i = 1'b1; tick(); clr_stat_i = 1'b0;
    chk("starve_clr", starve_cnt_o, 0);
    chk("sent_clr",   sent_cnt_o, 0);
    downlinkrdy_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("starve_nordy", starve_cnt_o, 0);
    chk("nordy_state",  state_o, 2);

    // prefill gating
    do_reset();
    for (int i = 1; i <= 3; i++) push(32'hA0 + i);
    enable_i = 1'b1; downlinkrdy_i = 1'b1;
    tick(); tick(); tick();
    chk("pf_state", state_o, 1);
    chk("pf_data",  downlinkUserData_o, 0);
    push(32'hA4);
    tick();
    chk("pf_run", state_o, 2);
    tick();
    chk("pf_first", downlinkUserData_o, 32'hA1);

    // full FIFO, dropped write, drain
    do_reset();
    for (int i = 0; i < 16; i++) push(32'hB000_0000 + i);
    chk("full",       full_o, 1);
    chk("full_ready", wr_if.wr_ready, 0);
    chk("full_count", count_o, 16);
    push(32'hDEAD_BEEF);
    chk("drop_count", count_o, 16);
    go_run();
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("drain", downlinkUserData_o, 32'hB000_0000 + i);
    end
    tick();
    chk("drain_end", downlinkUserData_o, 0);
    chk("drain_empty", empty_o, 1);

    // enable drop mid-stream, then reset
    do_reset();
    for (int i = 0; i < 8; i++) push(32'hC0 + i);
    go_run();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_data", downlinkUserData_o, 32'hC0 + i);
    end
    enable_i = 1'b0;
    tick();
    chk("mid_idle",  downlinkUserData_o, 0);
    chk("mid_fv",    frame_valid_o, 0);
    chk("mid_state", state_o, 0);
    chk("mid_count", count_o, 5);
    rst_i = 1'b1; tick();
    chk("mid_rst_count", count_o, 0);
    chk("mid_rst_empty", empty_o, 1);
    rst_i = 1'b0; tick();

`ifdef DL_LOOP_EN
    // replay: X consumed first, then A,B,C loop without consumption
    do_reset();
    push(32'h0000_00FF); push(32'hA); push(32'hB); push(32'hC);
    go_run();
    tick();
    chk("lp_x", downlinkUserData_o, 32'hFF);
    loop_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("lp_data", downlinkUserData_o, 32'hA + (i % 3));
    end
    chk("lp_count", count_o, 3);
    chk("lp_ready", wr_if.wr_ready, 0);
    chk("lp_sent",  sent_cnt_o, 7);
    loop_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lp_consume", downlinkUserData_o, 32'hA + i);
    end
    chk("lp_empty", empty_o, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
